// File: rtl/cnn_frame_sched_pkg.sv
// Shared geometry constants and FSM encoding for the CNN frame scheduler.
package cnn_frame_sched_pkg;

    localparam int unsigned IMG_DIM = 28;
    localparam int unsigned K_DIM   = 5;
    localparam int unsigned OUT_DIM = 24;
    localparam int unsigned NPIX    = IMG_DIM * IMG_DIM;
    localparam int unsigned NWIN    = OUT_DIM * OUT_DIM;
    localparam int unsigned WIN_W   = K_DIM * K_DIM * 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFire,
        StStream,
        StWait
    } state_e;

endpackage

// File: rtl/cnn_window_mux.sv
// Combinational 5x5 window extraction from the frame buffer at origin (r, c).
module cnn_window_mux
    import cnn_frame_sched_pkg::*;
(
    input  logic [7:0]       i_buf [NPIX],
    input  logic [4:0]       i_r,
    input  logic [4:0]       i_c,
    output logic [WIN_W-1:0] o_win
);

    logic [9:0] w_base;

    assign w_base = 10'(i_r) * 10'(IMG_DIM) + 10'(i_c);

    always_comb begin
        o_win = '0;
        for (int i = 0; i < int'(K_DIM); i++) begin
            for (int j = 0; j < int'(K_DIM); j++) begin
                o_win[(i*K_DIM+j)*8 +: 8] = i_buf[w_base + 10'(i*IMG_DIM + j)];
            end
        end
    end

endmodule

// File: rtl/cnn_frame_sched.sv
// Frame scheduler: loads a 28x28 image, streams all 24x24 conv windows to the CNN,
// then waits (with watchdog) for the class result.
module cnn_frame_sched
    import cnn_frame_sched_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = 32
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_go,
    input  logic             i_pix_valid,
    input  logic [7:0]       i_pix_data,
    output logic             o_pix_ready,
    output logic             o_cnn_start,
    output logic [4:0]       o_cnn_x,
    output logic [4:0]       o_cnn_y,
    output logic [WIN_W-1:0] o_cnn_imgin,
    input  logic             i_cnn_done,
    input  logic [3:0]       i_cnn_out,
    output logic             o_busy,
    output logic [3:0]       o_result,
    output logic             o_result_valid,
    output logic             o_err
);

    localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);

    state_e           r_state, w_state_next;
    logic [7:0]       r_buf [NPIX];
    logic [9:0]       r_pix_cnt;
    logic [4:0]       r_row, r_col;
    logic [WdogW-1:0] r_wdog;
    logic [3:0]       r_result;
    logic             r_result_valid, r_err;

    logic             w_pix_acc, w_last_pix, w_last_win, w_done_ok, w_timeout;
    logic [4:0]       w_nrow, w_ncol, w_win_r, w_win_c;
    logic [WIN_W-1:0] w_win;

    assign w_pix_acc  = (r_state == StLoad) && i_pix_valid;
    assign w_last_pix = w_pix_acc && (r_pix_cnt == 10'(NPIX - 1));
    assign w_last_win = (r_row == 5'(OUT_DIM - 1)) && (r_col == 5'(OUT_DIM - 1));
    assign w_done_ok  = (r_state == StWait) && i_cnn_done;
    assign w_timeout  = (r_state == StWait) && !i_cnn_done &&
                        (r_wdog == WdogW'(WDOG_CYCLES - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (i_go) w_state_next = StLoad;
            StLoad:   if (w_last_pix) w_state_next = StFire;
            StFire:   w_state_next = StStream;
            StStream: if (w_last_win) w_state_next = StWait;
            StWait:   if (w_done_ok || w_timeout) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) r_state <= StIdle;
        else         r_state <= w_state_next;
    end

    // IMGIN runs one window ahead of X/Y; the final window repeats (23,23).
    always_comb begin
        w_nrow = r_row;
        w_ncol = r_col + 5'd1;
        if (r_col == 5'(OUT_DIM - 1)) begin
            w_ncol = 5'd0;
            w_nrow = r_row + 5'd1;
            if (r_row == 5'(OUT_DIM - 1)) begin
                w_nrow = r_row;
                w_ncol = r_col;
            end
        end
    end

    assign w_win_r = (r_state == StStream) ? w_nrow : 5'd0;
    assign w_win_c = (r_state == StStream) ? w_ncol : 5'd0;

    cnn_window_mux u_window_mux (
        .i_buf (r_buf),
        .i_r   (w_win_r),
        .i_c   (w_win_c),
        .o_win (w_win)
    );

    // Pixel storage deliberately has no reset.
    always_ff @(posedge i_clk) begin
        if (i_nrst && w_pix_acc) r_buf[r_pix_cnt] <= i_pix_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_pix_cnt      <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_wdog         <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_go) begin
                        r_err     <= 1'b0;
                        r_pix_cnt <= '0;
                    end
                end
                StLoad: if (w_pix_acc) r_pix_cnt <= r_pix_cnt + 10'd1;
                StFire: begin
                    r_row  <= '0;
                    r_col  <= '0;
                    r_wdog <= '0;
                end
                StStream: begin
                    if (w_last_win) begin
                        r_row <= '0;
                        r_col <= '0;
                    end else begin
                        r_row <= w_nrow;
                        r_col <= w_ncol;
                    end
                end
                StWait: begin
                    r_wdog <= r_wdog + WdogW'(1);
                    if (w_done_ok) begin
                        r_result       <= i_cnn_out;
                        r_result_valid <= 1'b1;
                    end
                    if (w_timeout) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_pix_ready    = (r_state == StLoad);
    assign o_cnn_start    = (r_state == StFire);
    assign o_cnn_x        = (r_state == StStream) ? r_row : 5'd0;
    assign o_cnn_y        = (r_state == StStream) ? r_col : 5'd0;
    assign o_cnn_imgin    = (r_state == StFire || r_state == StStream) ? w_win : '0;
    assign o_busy         = (r_state != StIdle);
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_err          = r_err;

endmodule

// File: tb/tb_cnn_frame_sched.sv
// Directed bench for cnn_frame_sched: window table checks, result capture, watchdog, reset.
module tb_cnn_frame_sched;
    import cnn_frame_sched_pkg::*;

    localparam int CAPN = 620;

    logic             clk = 1'b0;
    logic             i_nrst, i_go, i_pix_valid, i_cnn_done;
    logic [7:0]       i_pix_data;
    logic [3:0]       i_cnn_out;
    logic             o_pix_ready, o_cnn_start, o_busy, o_result_valid, o_err;
    logic [4:0]       o_cnn_x, o_cnn_y;
    logic [WIN_W-1:0] o_cnn_imgin;
    logic [3:0]       o_result;

    always #5 clk = ~clk;

    cnn_frame_sched #(.WDOG_CYCLES(32)) dut (
        .i_clk          (clk),
        .i_nrst         (i_nrst),
        .i_go           (i_go),
        .i_pix_valid    (i_pix_valid),
        .i_pix_data     (i_pix_data),
        .o_pix_ready    (o_pix_ready),
        .o_cnn_start    (o_cnn_start),
        .o_cnn_x        (o_cnn_x),
        .o_cnn_y        (o_cnn_y),
        .o_cnn_imgin    (o_cnn_imgin),
        .i_cnn_done     (i_cnn_done),
        .i_cnn_out      (i_cnn_out),
        .o_busy         (o_busy),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .o_err          (o_err)
    );

    typedef struct {
        int         t;
        logic       exp_start;
        logic [4:0] exp_x;
        logic [4:0] exp_y;
        int         bsel;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs [16];

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIN_W-1:0] cap_img   [CAPN];
    logic [4:0]       cap_x     [CAPN];
    logic [4:0]       cap_y     [CAPN];
    logic [3:0]       cap_res   [CAPN];
    logic             cap_start [CAPN];
    logic             cap_busy  [CAPN];
    logic             cap_rv    [CAPN];
    logic             cap_err   [CAPN];

    task automatic chk(input string name, input logic [WIN_W-1:0] act,
                       input logic [WIN_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_go();
        @(negedge clk);
        i_go = 1'b1;
        @(negedge clk);
        i_go = 1'b0;
    endtask

    task automatic send_frame(input bit gappy);
        int n = 0;
        int cyc = 0;
        int early = 0;
        bit acc;
        while (n < int'(NPIX) && cyc < 4000) begin
            @(negedge clk);
            i_pix_valid = gappy ? (cyc % 2 == 0) : 1'b1;
            i_pix_data  = 8'(n % 256);
            if (o_cnn_start) early++;
            acc = i_pix_valid && o_pix_ready;
            @(posedge clk);
            if (acc) n++;
            cyc++;
        end
        #1 i_pix_valid = 1'b0;
        chk("load_beats", WIN_W'(n), WIN_W'(NPIX));
        chk("early_start", WIN_W'(early), '0);
    endtask

    task automatic capture(input int done_at, input int spur_at, input int go_at);
        for (int t = 0; t < CAPN; t++) begin
            @(negedge clk);
            cap_img[t]   = o_cnn_imgin;
            cap_x[t]     = o_cnn_x;
            cap_y[t]     = o_cnn_y;
            cap_res[t]   = o_result;
            cap_start[t] = o_cnn_start;
            cap_busy[t]  = o_busy;
            cap_rv[t]    = o_result_valid;
            cap_err[t]   = o_err;
            i_cnn_done   = (t == done_at) || (t == spur_at);
            i_cnn_out    = (t == done_at) ? 4'd7 : 4'd3;
            i_go         = (t == go_at);
        end
        i_cnn_done = 1'b0;
        i_go       = 1'b0;
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 16; i++) begin
            vec_t v = vecs[i];
            chk($sformatf("%s_t%0d_start", tag, v.t), WIN_W'(cap_start[v.t]),
                WIN_W'(v.exp_start));
            chk($sformatf("%s_t%0d_x", tag, v.t), WIN_W'(cap_x[v.t]), WIN_W'(v.exp_x));
            chk($sformatf("%s_t%0d_y", tag, v.t), WIN_W'(cap_y[v.t]), WIN_W'(v.exp_y));
            chk($sformatf("%s_t%0d_b%0d", tag, v.t, v.bsel),
                WIN_W'(cap_img[v.t][v.bsel*8 +: 8]), WIN_W'(v.exp_byte));
        end
    endtask

    task automatic count_phases(output int n_stream, output int n_wait);
        n_stream = 0;
        n_wait   = 0;
        for (int t = 1; t < CAPN; t++) begin
            if (cap_img[t] != '0) n_stream++;
            else if (cap_busy[t]) n_wait++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ns, nw;
        // Pixel(r,c) = (r*28+c)%256; t=0 is FIRE, t=k+1 is STREAM cycle k.
        vecs[0]  = '{0,   1'b1, 5'd0,  5'd0,  0,  8'd0};
        vecs[1]  = '{0,   1'b1, 5'd0,  5'd0,  5,  8'd28};
        vecs[2]  = '{0,   1'b1, 5'd0,  5'd0,  24, 8'd116};
        vecs[3]  = '{1,   1'b0, 5'd0,  5'd0,  0,  8'd1};
        vecs[4]  = '{23,  1'b0, 5'd0,  5'd22, 0,  8'd23};
        vecs[5]  = '{23,  1'b0, 5'd0,  5'd22, 4,  8'd27};
        vecs[6]  = '{23,  1'b0, 5'd0,  5'd22, 5,  8'd51};
        vecs[7]  = '{24,  1'b0, 5'd0,  5'd23, 0,  8'd28};
        vecs[8]  = '{24,  1'b0, 5'd0,  5'd23, 4,  8'd32};
        vecs[9]  = '{101, 1'b0, 5'd4,  5'd4,  0,  8'd117};
        vecs[10] = '{101, 1'b0, 5'd4,  5'd4,  12, 8'd175};
        vecs[11] = '{301, 1'b0, 5'd12, 5'd12, 0,  8'd93};
        vecs[12] = '{301, 1'b0, 5'd12, 5'd12, 24, 8'd209};
        vecs[13] = '{575, 1'b0, 5'd23, 5'd22, 0,  8'd155};
        vecs[14] = '{576, 1'b0, 5'd23, 5'd23, 24, 8'd15};
        vecs[15] = '{577, 1'b0, 5'd0,  5'd0,  0,  8'd0};

        i_nrst = 1'b0; i_go = 1'b0; i_pix_valid = 1'b0; i_pix_data = '0;
        i_cnn_done = 1'b0; i_cnn_out = '0;
        repeat (3) @(negedge clk);
        i_nrst = 1'b1;
        @(negedge clk);
        chk("rst_busy",  WIN_W'(o_busy), '0);
        chk("rst_ready", WIN_W'(o_pix_ready), '0);
        chk("rst_start", WIN_W'(o_cnn_start), '0);
        chk("rst_imgin", o_cnn_imgin, '0);
        chk("rst_result", WIN_W'({o_result, o_result_valid, o_err}), '0);

        // Frame 1: continuous pixels, spurious DONE and GO mid-stream, real DONE in WAIT.
        do_go();
        chk("go_ready", WIN_W'(o_pix_ready), WIN_W'(1));
        send_frame(1'b0);
        capture(588, 50, 100);
        check_table("f1");
        count_phases(ns, nw);
        chk("f1_stream_len", WIN_W'(ns), WIN_W'(NWIN));
        chk("f1_spur_done_rv", WIN_W'(cap_rv[51]), '0);
        chk("f1_wait_busy", WIN_W'(cap_busy[588]), WIN_W'(1));
        chk("f1_res_before", WIN_W'(cap_res[588]), '0);
        chk("f1_rv", WIN_W'(cap_rv[589]), WIN_W'(1));
        chk("f1_result", WIN_W'(cap_res[589]), WIN_W'(7));
        chk("f1_busy_after", WIN_W'(cap_busy[589]), '0);
        chk("f1_rv_pulse", WIN_W'(cap_rv[590]), '0);
        chk("f1_err", WIN_W'(cap_err[600]), '0);

        // Frame 2: 50% PIX_VALID, no DONE -> watchdog.
        do_go();
        send_frame(1'b1);
        capture(-1, -1, -1);
        check_table("f2");
        count_phases(ns, nw);
        chk("f2_stream_len", WIN_W'(ns), WIN_W'(NWIN));
        chk("f2_wait_len", WIN_W'(nw), WIN_W'(32));
        chk("f2_err_pre", WIN_W'(cap_err[608]), '0);
        chk("f2_busy_pre", WIN_W'(cap_busy[608]), WIN_W'(1));
        chk("f2_err", WIN_W'(cap_err[609]), WIN_W'(1));
        chk("f2_busy_after", WIN_W'(cap_busy[609]), '0);
        chk("f2_res_kept", WIN_W'(cap_res[609]), WIN_W'(7));
        chk("f2_no_rv", WIN_W'(cap_rv[609]), '0);

        // Frame 3: GO clears ERR, then reset mid-stream at k=100.
        do_go();
        chk("f3_err_clr", WIN_W'(o_err), '0);
        chk("f3_ready", WIN_W'(o_pix_ready), WIN_W'(1));
        send_frame(1'b0);
        for (int t = 0; t <= 101; t++) @(negedge clk);
        chk("f3_x_k100", WIN_W'(o_cnn_x), WIN_W'(4));
        chk("f3_y_k100", WIN_W'(o_cnn_y), WIN_W'(4));
        i_nrst = 1'b0;
        @(negedge clk);
        i_nrst = 1'b1;
        chk("f3_rst_busy", WIN_W'(o_busy), '0);
        chk("f3_rst_xy", WIN_W'({o_cnn_x, o_cnn_y, o_cnn_start}), '0);
        chk("f3_rst_imgin", o_cnn_imgin, '0);
        chk("f3_rst_result", WIN_W'({o_result, o_result_valid, o_err}), '0);
        i_pix_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("f3_ready_idle", WIN_W'(o_pix_ready), '0);
        chk("f3_busy_idle", WIN_W'(o_busy), '0);
        i_pix_valid = 1'b0;
        do_go();
        chk("f3_ready_go", WIN_W'(o_pix_ready), WIN_W'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_frame_sched.md
CNN_FRAME_SCHED -- requirements
Module: cnn_frame_sched

Interface
REQ-001 Parameter WDOG_CYCLES, default 32, SHALL set the cycle limit waiting for CNN_DONE after streaming ends.
REQ-002 CLK  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-003 nRST  input  1  SHALL be the synchronous, active-low reset.
REQ-004 GO  input  1  SHALL start a frame when sampled high in IDLE.
REQ-005 PIX_VALID  input  1  SHALL qualify PIX_DATA.
REQ-006 PIX_DATA  input  8  SHALL carry one unsigned pixel, raster order (row 0 col 0 first).
REQ-007 PIX_READY  output  1  SHALL be high only in LOAD.
REQ-008 CNN_START  output  1  SHALL pulse for one cycle to start the CNN.
REQ-009 CNN_X  output  5  SHALL be the conv row index (0..23).
REQ-010 CNN_Y  output  5  SHALL be the conv column index (0..23).
REQ-011 CNN_IMGIN  output  200  SHALL be the 5x5 window: byte i*5+j at bits [(i*5+j)*8 +: 8] = pixel(row r+i, col c+j).
REQ-012 CNN_DONE  input  1  SHALL be the CNN completion pulse.
REQ-013 CNN_OUT  input  4  SHALL be the CNN class result, valid with CNN_DONE.
REQ-014 BUSY  output  1  SHALL be high in every state except IDLE.
REQ-015 RESULT  output  4  SHALL hold the last captured class.
REQ-016 RESULT_VALID  output  1  SHALL pulse for one cycle when RESULT updates.
REQ-017 ERR  output  1  SHALL be sticky high after a watchdog timeout; cleared on the next accepted GO.

Function
REQ-018 States SHALL be IDLE, LOAD, FIRE, STREAM, WAIT; IDLE->LOAD on GO.
REQ-019 LOAD SHALL write a pixel into the 784-byte buffer on each PIX_VALID&&PIX_READY cycle; gaps in PIX_VALID SHALL not advance the counter.
REQ-020 After the 784th accepted pixel, the next state SHALL be FIRE; PIX_READY SHALL drop in that same edge.
REQ-021 FIRE (one cycle) SHALL drive CNN_START=1, CNN_X=CNN_Y=0, CNN_IMGIN=window(0,0), then enter STREAM.
REQ-022 STREAM SHALL last exactly 576 cycles; in cycle k (0..575): CNN_X=k/24, CNN_Y=k%24, CNN_IMGIN=window(k+1) for k<575, window(23,23) for k=575.
REQ-023 Window(k) SHALL use r=k/24, c=k%24; X/Y SHALL lag IMGIN by one window.
REQ-024 Row/column counters SHALL wrap column 23->0 with row increment; no division hardware.
REQ-025 After STREAM, WAIT SHALL count cycles; CNN_DONE seen -> RESULT<=CNN_OUT, RESULT_VALID=1 next cycle, state IDLE.
REQ-026 WAIT reaching WDOG_CYCLES without CNN_DONE SHALL set ERR, leave RESULT unchanged, return to IDLE.
REQ-027 CNN_DONE outside WAIT SHALL be ignored; GO outside IDLE SHALL be ignored.
REQ-028 CNN_START SHALL be 0 in every state except FIRE.

Reset
REQ-029 nRST low at a clock edge SHALL force IDLE and zero BUSY, PIX_READY, CNN_START, CNN_X, CNN_Y, CNN_IMGIN, RESULT, RESULT_VALID, ERR, all counters, in any state.
REQ-030 The pixel buffer SHALL not be reset; a new GO is required after reset.

Structure
REQ-031 A shared package SHALL hold IMG_DIM=28, K_DIM=5, OUT_DIM=24, NPIX=784, NWIN=576 and the state encoding.
REQ-032 Window extraction SHALL be one combinational sub-module, cnn_window_mux (buffer, r, c -> 200-bit window).

Verification
REQ-033 Pixel(r,c)=(r*28+c)%256, GO -> at CNN_START: IMGIN byte0=0, byte5=28, byte24=116.
REQ-034 Same frame -> exactly 576 STREAM cycles after CNN_START; last cycle X=23,Y=23; first cycle X=0,Y=0 with IMGIN byte0=1.
REQ-035 CNN model asserts DONE with OUT=7 twelve cycles after STREAM -> RESULT=7, RESULT_VALID high one cycle, BUSY low after.
REQ-036 No CNN_DONE -> ERR=1 after 32 WAIT cycles, IDLE, RESULT unchanged; next GO clears ERR.
REQ-037 PIX_VALID toggled 50% -> FIRE only after 784 accepted beats; buffer contents match pixels sent.
REQ-038 nRST low one cycle at STREAM k=100 -> all outputs 0 next edge, PIX_READY 0 until GO.
